// File: rtl/sprite_painter.sv
// Sprite pixel engine: paints a SIZE x SIZE square (draw or erase) one pixel per
// cycle into the VGA adapter, then reports completion via a four-phase handshake.
module sprite_painter #(
  parameter int unsigned SIZE     = 4,
  parameter logic [2:0]  BG_COLOR = 3'b000,
  parameter int unsigned X_MAX    = 160,
  parameter int unsigned Y_MAX    = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] color_in,
  input  logic       start_draw,
  input  logic       start_erase,
  output logic       done_draw,
  output logic       done_erase,
  output logic       busy,
  output logic       plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_color
);

  localparam logic [2:0] LAST  = 3'(SIZE - 1);
  localparam logic [8:0] X_LIM = 9'(X_MAX);
  localparam logic [7:0] Y_LIM = 8'(Y_MAX);

  typedef enum logic [1:0] {S_IDLE, S_PAINT, S_DONE} state_t;

  state_t     state_q, state_d;
  logic       op_draw_q, op_draw_d;
  logic [7:0] x0_q, x0_d;
  logic [6:0] y0_q, y0_d;
  logic [2:0] col_q, col_d;
  logic [2:0] dx_q, dx_d;
  logic [2:0] dy_q, dy_d;
  logic       plot_q, plot_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] vga_col_q, vga_col_d;
  logic       done_draw_q, done_draw_d;
  logic       done_erase_q, done_erase_d;
  logic       busy_q, busy_d;

  logic [8:0] x_sum;
  logic [7:0] y_sum;
  logic       req_hold;

  // State and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      op_draw_q    <= 1'b0;
      x0_q         <= '0;
      y0_q         <= '0;
      col_q        <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      plot_q       <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_col_q    <= '0;
      done_draw_q  <= 1'b0;
      done_erase_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_draw_q    <= op_draw_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      col_q        <= col_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      plot_q       <= plot_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_col_q    <= vga_col_d;
      done_draw_q  <= done_draw_d;
      done_erase_q <= done_erase_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state, scan counters and pixel output
  always_comb begin
    state_d   = state_q;
    op_draw_d = op_draw_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    col_d     = col_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    plot_d    = 1'b0;
    vga_x_d   = vga_x_q;
    vga_y_d   = vga_y_q;
    vga_col_d = vga_col_q;

    x_sum    = {1'b0, x0_q} + {6'b0, dx_q};
    y_sum    = {1'b0, y0_q} + {5'b0, dy_q};
    req_hold = op_draw_q ? start_draw : start_erase;

    case (state_q)
      S_IDLE: begin
        if (start_draw) begin
          x0_d      = x_in;
          y0_d      = y_in;
          col_d     = color_in;
          op_draw_d = 1'b1;
          dx_d      = '0;
          dy_d      = '0;
          state_d   = S_PAINT;
        end else if (start_erase) begin
          x0_d      = x_in;
          y0_d      = y_in;
          col_d     = BG_COLOR;
          op_draw_d = 1'b0;
          dx_d      = '0;
          dy_d      = '0;
          state_d   = S_PAINT;
        end
      end
      S_PAINT: begin
        // Off-frame pixels still consume their scan cycle, just without a write
        plot_d    = (x_sum < X_LIM) && (y_sum < Y_LIM);
        vga_x_d   = x_sum[7:0];
        vga_y_d   = y_sum[6:0];
        vga_col_d = col_q;
        if (dx_q == LAST) begin
          dx_d = '0;
          if (dy_q == LAST) begin
            dy_d    = '0;
            state_d = S_DONE;
          end else begin
            dy_d = dy_q + 3'd1;
          end
        end else begin
          dx_d = dx_q + 3'd1;
        end
      end
      S_DONE: begin
        if (!req_hold) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d       = (state_d != S_IDLE);
    done_draw_d  = (state_q == S_DONE) && (state_d == S_DONE) && op_draw_q;
    done_erase_d = (state_q == S_DONE) && (state_d == S_DONE) && !op_draw_q;
  end

  assign plot       = plot_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_color  = vga_col_q;
  assign done_draw  = done_draw_q;
  assign done_erase = done_erase_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sprite_painter.sv
// Scoreboard bench for sprite_painter: expected pixels are queued at request time
// and a monitor pops and compares every plotted pixel.
module tb_sprite_painter;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] color_in;
  logic       start_draw, start_erase;
  logic       done_draw, done_erase, busy, plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_color;

  always #10 clk = ~clk;

  sprite_painter dut (
    .clk(clk), .resetn(resetn), .x_in(x_in), .y_in(y_in), .color_in(color_in),
    .start_draw(start_draw), .start_erase(start_erase),
    .done_draw(done_draw), .done_erase(done_erase), .busy(busy), .plot(plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color)
  );

  logic [17:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int plot_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Queue the on-frame pixels of a 4x4 square in row-major order, up to lim entries
  task automatic push_sq(input int x, input int y, input logic [2:0] c, input int lim);
    int n = 0;
    for (int dy = 0; dy < 4; dy++)
      for (int dx = 0; dx < 4; dx++)
        if ((x + dx) < 160 && (y + dy) < 120 && n < lim) begin
          exp_q.push_back({8'(x + dx), 7'(y + dy), c});
          n++;
        end
  endtask

  // Called at the negedge where the request is raised; returns one negedge after done seen
  task automatic wait_done(input bit draw, input string nm, input int exp_lat, input int exp_plots);
    int cyc = -1;
    int p0 = plot_cnt;
    bit other = 1'b0;
    bit got = 1'b0;
    while (cyc < 60 && !got) begin
      @(negedge clk);
      cyc++;
      if (draw ? done_erase : done_draw) other = 1'b1;
      if (draw ? done_draw : done_erase) got = 1'b1;
    end
    chk({nm, " done seen"}, int'(got), 1);
    if (exp_lat > 0) chk({nm, " latency"}, cyc, exp_lat);
    chk({nm, " plot count"}, plot_cnt - p0, exp_plots);
    chk({nm, " wrong done"}, int'(other), 0);
    @(negedge clk);
    chk({nm, " done held"}, int'(draw ? done_draw : done_erase), 1);
    chk({nm, " busy in done"}, int'(busy), 1);
  endtask

  initial begin
    resetn = 1'b0; x_in = '0; y_in = '0; color_in = '0;
    start_draw = 1'b0; start_erase = 1'b0;
    fork
      begin : monitor
        logic [17:0] e;
        forever begin
          @(negedge clk);
          if (plot === 1'b1) begin
            plot_cnt++;
            chk("plot outside busy", int'(busy), 1);
            if (exp_q.size() == 0) begin
              chk("unexpected pixel", int'({vga_x, vga_y, vga_color}), -1);
            end else begin
              e = exp_q.pop_front();
              chk("pixel", int'({vga_x, vga_y, vga_color}), int'(e));
            end
          end
        end
      end
      begin : stim
        repeat (3) @(negedge clk);
        chk("reset outputs", int'({plot, vga_x, vga_y, vga_color, done_draw, done_erase, busy}), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Basic draw
        x_in = 8'd8; y_in = 7'd4; color_in = 3'b101; start_draw = 1'b1;
        push_sq(8, 4, 3'b101, 16);
        wait_done(1'b1, "draw", 17, 16);
        start_draw = 1'b0;
        @(negedge clk);
        chk("draw done fall", int'(done_draw), 0);
        chk("draw busy fall", int'(busy), 0);

        // Erase at the bottom-right corner, colour input must be ignored
        x_in = 8'd156; y_in = 7'd116; color_in = 3'b111; start_erase = 1'b1;
        push_sq(156, 116, 3'b000, 16);
        wait_done(1'b0, "erase", 17, 16);
        start_erase = 1'b0;
        @(negedge clk);
        chk("erase done fall", int'(done_erase), 0);
        chk("erase busy fall", int'(busy), 0);

        // Clipped draw: only 4 of 16 scan cycles plot
        x_in = 8'd158; y_in = 7'd118; color_in = 3'b010; start_draw = 1'b1;
        push_sq(158, 118, 3'b010, 16);
        wait_done(1'b1, "clip", 17, 4);
        start_draw = 1'b0;
        @(negedge clk);

        // Both requests: draw wins, erase follows once draw is released
        x_in = 8'd40; y_in = 7'd50; color_in = 3'b110;
        start_draw = 1'b1; start_erase = 1'b1;
        push_sq(40, 50, 3'b110, 16);
        wait_done(1'b1, "both draw", 17, 16);
        start_draw = 1'b0;
        push_sq(40, 50, 3'b000, 16);
        wait_done(1'b0, "both erase", -1, 16);
        start_erase = 1'b0;
        @(negedge clk);

        // Reset mid-paint, with x_in disturbed after the request was latched
        begin
          int p0;
          x_in = 8'd20; y_in = 7'd30; color_in = 3'b011; start_draw = 1'b1;
          push_sq(20, 30, 3'b011, 5);
          p0 = plot_cnt;
          @(negedge clk);
          x_in = 8'd99;
          repeat (5) @(negedge clk);
          resetn = 1'b0;
          @(negedge clk);
          chk("abort outputs", int'({plot, vga_x, vga_y, vga_color, done_draw, done_erase, busy}), 0);
          chk("abort plot count", plot_cnt - p0, 5);
          start_draw = 1'b0;
          @(negedge clk);
          resetn = 1'b1;
          repeat (3) @(negedge clk);
          chk("idle after abort", int'({plot, busy, done_draw}), 0);
        end

        chk("scoreboard empty", exp_q.size(), 0);
      end
      begin : watchdog
        repeat (2000) @(negedge clk);
        chk("global timeout", 1, 0);
      end
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_painter.md
# sprite_painter

Pixel-generation engine between the game control FSM and the VGA adapter. On a draw or erase request it latches the sprite origin and colour, then emits one plot per cycle to cover a SIZE×SIZE square on the 160×120 frame buffer. Erase repaints the same square in the background colour. Completion is reported back to the control FSM through a four-phase request/done handshake.

## Interface
Parameters:
- SIZE, 4, sprite edge length in pixels; legal range 1..8.
- BG_COLOR, 3'b000, colour written on erase.
- X_MAX, 160, frame width; pixels with x ≥ X_MAX are clipped.
- Y_MAX, 120, frame height; pixels with y ≥ Y_MAX are clipped.

Ports:
- clk  in  1  system clock (50 MHz).
- resetn  in  1  reset; synchronous, active-low.
- x_in  in  8  sprite origin x (top-left).
- y_in  in  7  sprite origin y (top-left).
- color_in  in  3  sprite colour for draw.
- start_draw  in  1  draw request; held high until done_draw seen.
- start_erase  in  1  erase request; held high until done_erase seen.
- done_draw  out  1  draw complete; high in DONE while the op is draw.
- done_erase  out  1  erase complete; high in DONE while the op is erase.
- busy  out  1  high in PAINT and DONE.
- plot  out  1  VGA adapter write enable.
- vga_x  out  8  pixel x to the adapter.
- vga_y  out  7  pixel y to the adapter.
- vga_color  out  3  pixel colour to the adapter.

## Operation
- States: IDLE, PAINT, DONE.
- IDLE: if start_draw=1, latch x_in, y_in, color_in, set op=draw, clear dx/dy, go to PAINT. Else if start_erase=1, latch x_in, y_in, take colour BG_COLOR, set op=erase, go to PAINT. start_draw wins when both are high.
- PAINT: each cycle emits pixel (x0+dx, y0+dy) with the latched colour. Scan is row-major: dx increments fastest, 0..SIZE-1, then wraps to 0 and dy increments. After (SIZE-1, SIZE-1), go to DONE.
- Coordinates are summed at 9/8 bits. If x0+dx ≥ X_MAX or y0+dy ≥ Y_MAX, plot=0 for that cycle; the scan still consumes the cycle.
- DONE: assert done_draw or done_erase according to op. Stay in DONE while the matching start is high. When it goes low, return to IDLE on the next edge.
- Inputs x_in, y_in, color_in, and both starts are ignored in PAINT. The opposite start is ignored in DONE.
- dx and dy are 3-bit counters.

## Timing
- Reset: state=IDLE, and plot, vga_x, vga_y, vga_color, done_draw, done_erase, busy are all 0. Reset asserted mid-PAINT or mid-DONE aborts at the next edge with no further plots. Partially painted pixels are left as-is.
- plot, vga_x, vga_y, vga_color are registered.
- Start sampled at edge 0 → first pixel valid after edge 1 → SIZE² consecutive pixel cycles (16 for SIZE=4) → done high after edge SIZE²+1.
- plot is never high outside PAINT-output cycles.
- Done falls one cycle after its start falls. A new request is accepted no earlier than the cycle after returning to IDLE.
- done_draw and done_erase are decoded from registered state/op and are glitch-free.
- Minimum draw round trip for SIZE=4: 19 cycles, including a one-cycle start drop.

## Test plan
- Reset, then start_draw=1 with x_in=8, y_in=4, color_in=3'b101 → 16 plot cycles covering (8..11, 4..7) in row-major order, all with colour 101. done_draw rises on cycle 17. Dropping start_draw → done_draw=0 and busy=0 one cycle later.
- start_erase with x_in=156, y_in=116 → 16 plots covering (156..159, 116..119), colour 000, done_erase asserted, done_draw never asserted.
- Clipping: start_draw with x_in=158, y_in=118 → 16 scan cycles but only 4 plots, at (158..159, 118..119).
- start_draw and start_erase both high in IDLE → draw executes with color_in. After start_draw drops and start_erase stays high, erase executes next.
- resetn=0 on the 6th PAINT cycle → plot=0 from the next edge, state IDLE, all outputs 0. Changing x_in during PAINT has no effect on emitted coordinates.
